nes_joypad_port: RTL and testbench
==================================

Name: nes_joypad_port

Overview:
- CPU-bus responder for the two NES controller ports at $4016/$4017.
- Answers CPU reads on the shared tri-state data bus.
- Takes the strobe write at $4016.
- Autonomously polls two serial 4021-style pads through a latch/clock/data FSM.
- Presents the standard NES serial-read semantics to software.

Parameters:
- PAD_HALF, 6: clk cycles per pad half-bit phase; must be ≥1.
- POLL_PERIOD, 4096: idle clk cycles between pad polls; must be ≥2.
- PCW, 16: width of the poll counter; must satisfy 2^PCW > POLL_PERIOD.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: asynchronous, active-high
- addr  in  16  CPU address
- rd  in  1  one-cycle qualified CPU read strobe
- wr  in  1  one-cycle qualified CPU write strobe
- stall  in  1  CPU stalled; any access this cycle is ignored
- data  inout  8  CPU data bus; driven only on a responding read
- pad_latch  out  1  latch to both pads, active-high
- pad_clk  out  1  shift clock to both pads; bit advances on rising edge
- pad_data0  in  1  serial data from pad 0, active-low (0 = pressed)
- pad_data1  in  1  serial data from pad 1, active-low (0 = pressed)
- buttons0  out  8  committed pad-0 state, 1 = pressed; bit0..7 = A,B,Sel,Start,Up,Down,Left,Right
- buttons1  out  8  committed pad-1 state, same encoding

Behaviour:
Reset:
- strobe=0; sr0=sr1=8'hFF; buttons0=buttons1=8'h00.
- pad_latch=0; pad_clk=0; FSM=IDLE; poll counter=0; data released (Z).

Access decode (all gated by ~stall):
- hit0 = addr==16'h4016; hit1 = addr==16'h4017.
- wr&hit0: strobe <= data[0]. Writes to $4017 are ignored (owned elsewhere).
- rd&(hit0|hit1), wr=0: drive data combinationally that same cycle; 8'h40 | sr0[0] for $4016, 8'h40 | sr1[0] for $4017.
- rd and wr both high: write wins; no read response, no shift.

Shift registers:
- Any cycle with the registered strobe==1: sr0<=buttons0, sr1<=buttons1. No shift occurs.
- The write cycle that clears strobe still loads, because the registered strobe is still 1 that cycle.
- Responding read with strobe==0: the addressed sr <= {1'b1, sr[7:1]} at the clock edge ending that read.
- After 8 reads, every further read returns bit0=1.
- Read with strobe==1: returns buttons bit0 (A), with no shift.

Pad FSM states:
- IDLE
  - Counter increments each cycle.
  - At POLL_PERIOD-1: counter<=0, go LATCH.
- LATCH
  - pad_latch=1 for 2*PAD_HALF cycles, then go LOW with k=0.
- LOW
  - pad_clk=0 for PAD_HALF cycles.
  - On the last cycle, sample tmp0[k] <= ~pad_data0 and tmp1[k] <= ~pad_data1.
  - If k==7, go DONE; else go HIGH.
- HIGH
  - pad_clk=1 for PAD_HALF cycles, then k<=k+1 and go LOW.
- DONE
  - One cycle: buttons0<=tmp0 and buttons1<=tmp1, committed atomically; go IDLE.

Pad timing and ordering:
- A poll lasts 17*PAD_HALF+1 cycles.
- pad_latch and pad_clk are registered outputs; they are never high simultaneously.
- When a commit coincides with a strobe-high cycle, sr loads the pre-commit buttons that cycle and the new value from the next cycle on.
- The pad FSM runs independently of stall and of CPU accesses.

Reset mid-poll:
- Outputs return to reset values immediately.
- The partial sample is discarded.

Test Plan (PAD_HALF=2, POLL_PERIOD=64):
- Reset, then wait 64 cycles.
  - pad_latch high for exactly 4 cycles.
  - Then 7 pad_clk pulses, each 2 cycles high.
  - Then buttons0/buttons1 commit in the DONE cycle.
- Pad0 serial stream (active-low) = 0,1,1,0,1,1,1,0 for bits A..Right; pad1 idle-high.
  - buttons0=8'h89, buttons1=8'h00.
- With buttons0=8'h89: write $4016←1, write $4016←0, then 10 reads of $4016.
  - data = 41,40,40,41,40,40,40,41,41,41.
- Strobe left at 1, 3 reads of $4016 with buttons0=8'h01.
  - Each read returns 8'h41; sr0 never shifts.
- Read $4016 with stall=1; separately, rd and wr both high to $4016.
  - data stays Z, sr0 is unchanged, and the write takes effect.
- Assert rst during the LOW phase of k=3.
  - pad_clk=0 and pad_latch=0 immediately; buttons=00; the next poll starts 64 cycles after release.

Source files
------------

// File: rtl/nes_joypad_port.sv
// NES controller port responder for $4016/$4017.
// Bus access contract: rd and wr are single-cycle qualified strobes sampled
// on the rising clk edge; any access in a cycle with stall=1 is ignored.
// When rd and wr arrive together, the write is taken and the read is dropped.
// A responding read drives data combinationally in the same cycle. The
// shift caused by that read happens at the clock edge that ends the cycle.
// Two 4021-style pads are polled autonomously by a latch/clock/data FSM.
module nes_joypad_port #(
    parameter int PAD_HALF    = 6,
    parameter int POLL_PERIOD = 4096,
    parameter int PCW         = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic        stall,
    inout  wire  [7:0]  data,
    output logic        pad_latch,
    output logic        pad_clk,
    input  logic        pad_data0,
    input  logic        pad_data1,
    output logic [7:0]  buttons0,
    output logic [7:0]  buttons1
);

    localparam int PW = $clog2(2 * PAD_HALF + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t         state, state_n;
    logic [PCW-1:0] poll_cnt, poll_cnt_n;
    logic [PW-1:0]  ph, ph_n;
    logic [2:0]     k, k_n;
    logic           sample, commit;
    logic [7:0]     tmp0, tmp1;

    logic           strobe;
    logic [7:0]     sr0, sr1;
    logic           hit0, hit1, wr_ok, rd_ok, wr_strobe, rd0, rd1;
    logic           rbit;
    logic [7:0]     rdata;
    logic           unused_data;

    // CPU access decode; stall cancels everything, write beats read
    always_comb begin
        hit0      = (addr == 16'h4016);
        hit1      = (addr == 16'h4017);
        wr_ok     = wr & ~stall;
        rd_ok     = rd & ~stall & ~wr;
        wr_strobe = wr_ok & hit0;
        rd0       = rd_ok & hit0;
        rd1       = rd_ok & hit1;
    end

    // Read data: while strobe is held, report the live A button
    always_comb begin
        rbit = 1'b0;
        if (hit0) rbit = strobe ? buttons0[0] : sr0[0];
        else      rbit = strobe ? buttons1[0] : sr1[0];
        rdata = 8'h40 | {7'b0, rbit};
    end

    assign data        = (rd0 | rd1) ? rdata : 8'hzz;
    assign unused_data = ^data[7:1];

    // Strobe register, written only through $4016
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            strobe <= 1'b0;
        else if (wr_strobe) strobe <= data[0];
    end

    // Serial shift registers: reload while strobe is held, else shift on read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr0 <= 8'hFF;
            sr1 <= 8'hFF;
        end else if (strobe) begin
            sr0 <= buttons0;
            sr1 <= buttons1;
        end else begin
            if (rd0) sr0 <= {1'b1, sr0[7:1]};
            if (rd1) sr1 <= {1'b1, sr1[7:1]};
        end
    end

    // Pad poll FSM: next-state, counters and sample/commit pulses
    always_comb begin
        state_n    = state;
        poll_cnt_n = poll_cnt;
        ph_n       = ph;
        k_n        = k;
        sample     = 1'b0;
        commit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (poll_cnt == PCW'(POLL_PERIOD - 1)) begin
                    poll_cnt_n = '0;
                    ph_n       = '0;
                    state_n    = S_LATCH;
                end else begin
                    poll_cnt_n = poll_cnt + 1'b1;
                end
            end
            S_LATCH: begin
                if (ph == PW'(2 * PAD_HALF - 1)) begin
                    ph_n    = '0;
                    k_n     = 3'd0;
                    state_n = S_LOW;
                end else begin
                    ph_n = ph + 1'b1;
                end
            end
            S_LOW: begin
                if (ph == PW'(PAD_HALF - 1)) begin
                    ph_n    = '0;
                    sample  = 1'b1;
                    state_n = (k == 3'd7) ? S_DONE : S_HIGH;
                end else begin
                    ph_n = ph + 1'b1;
                end
            end
            S_HIGH: begin
                if (ph == PW'(PAD_HALF - 1)) begin
                    ph_n    = '0;
                    k_n     = k + 3'd1;
                    state_n = S_LOW;
                end else begin
                    ph_n = ph + 1'b1;
                end
            end
            S_DONE: begin
                commit  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Pad FSM state and registered pad outputs derived from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            poll_cnt  <= '0;
            ph        <= '0;
            k         <= 3'd0;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b0;
        end else begin
            state     <= state_n;
            poll_cnt  <= poll_cnt_n;
            ph        <= ph_n;
            k         <= k_n;
            pad_latch <= (state_n == S_LATCH);
            pad_clk   <= (state_n == S_HIGH);
        end
    end

    // Sample pad bits into scratch, then commit both pads together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmp0     <= 8'h00;
            tmp1     <= 8'h00;
            buttons0 <= 8'h00;
            buttons1 <= 8'h00;
        end else begin
            if (sample) begin
                tmp0[k] <= ~pad_data0;
                tmp1[k] <= ~pad_data1;
            end
            if (commit) begin
                buttons0 <= tmp0;
                buttons1 <= tmp1;
            end
        end
    end

endmodule

// File: tb/tb_nes_joypad_port.sv
// Bench for nes_joypad_port with PAD_HALF=2, POLL_PERIOD=64.
// Pads are emulated as 4021 shift registers; expected pad timing, committed
// buttons and CPU read data are computed from poll-position arithmetic and a
// snapshot/read-count model of the serial protocol.
module tb_nes_joypad_port;

    localparam int H  = 2;
    localparam int PP = 64;
    localparam int P  = PP + 17 * H + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic        rd, wr, stall;
    wire  [7:0]  data;
    logic        tb_en;
    logic [7:0]  tb_val;
    logic        pad_latch, pad_clk, pad_data0, pad_data1;
    logic [7:0]  buttons0, buttons1;

    assign data = tb_en ? tb_val : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup pu (data[i]);
    end

    nes_joypad_port #(.PAD_HALF(H), .POLL_PERIOD(PP), .PCW(16)) dut (
        .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr), .stall(stall),
        .data(data), .pad_latch(pad_latch), .pad_clk(pad_clk),
        .pad_data0(pad_data0), .pad_data1(pad_data1),
        .buttons0(buttons0), .buttons1(buttons1)
    );

    // clock
    always #5 clk = ~clk;

    // 4021 pad emulation: parallel load on latch, shift toward output on clk
    logic [7:0] pat0, pat1;
    logic [7:0] ps0 = 8'hFF;
    logic [7:0] ps1 = 8'hFF;
    assign pad_data0 = ps0[0];
    assign pad_data1 = ps1[0];
    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) begin
            ps0 = ~pat0;
            ps1 = ~pat1;
        end else begin
            ps0 = {1'b1, ps0[7:1]};
            ps1 = {1'b1, ps1[7:1]};
        end
    end

    // reference model state
    int         cyc, tests, fails;
    logic [7:0] exp_b0, exp_b1, lat0, lat1, snap0, snap1;
    logic       pend, exp_strobe, prev_clk;
    int         n0, n1, lat_cnt, clk_rise;

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // per-cycle check of pad outputs and committed buttons
    task automatic check_pads();
        int   p;
        logic el, ec;
        if (pend) begin
            exp_b0 = lat0;
            exp_b1 = lat1;
            pend   = 1'b0;
        end
        el = 1'b0;
        ec = 1'b0;
        p  = cyc % P;
        if (p >= PP) begin
            p = p - PP;
            if (p < 2 * H) el = 1'b1;
            else if (p < 17 * H) ec = (((p - 2 * H) / H) % 2) == 1;
            if (p == 0) begin
                lat0 = pat0;
                lat1 = pat1;
            end
            if (p == 17 * H) pend = 1'b1;
        end
        if (pad_latch === 1'b1) lat_cnt++;
        if (pad_clk === 1'b1 && prev_clk === 1'b0) clk_rise++;
        prev_clk = pad_clk;
        check8("pad_latch", {7'b0, pad_latch}, {7'b0, el});
        check8("pad_clk", {7'b0, pad_clk}, {7'b0, ec});
        check8("buttons0", buttons0, exp_b0);
        check8("buttons1", buttons1, exp_b1);
    endtask

    task automatic step();
        @(negedge clk);
        check_pads();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic cpu_read(input logic [15:0] a, input logic stl);
        logic [7:0] e;
        logic       b;
        addr  = a;
        rd    = 1'b1;
        stall = stl;
        @(negedge clk);
        check_pads();
        b = 1'b1;
        if (stl) begin
            e = 8'hFF;
        end else begin
            if (exp_strobe) begin
                b = (a == 16'h4016) ? exp_b0[0] : exp_b1[0];
            end else if (a == 16'h4016) begin
                if (n0 < 8) b = snap0[n0];
                n0++;
            end else begin
                if (n1 < 8) b = snap1[n1];
                n1++;
            end
            e = 8'h40 | {7'b0, b};
        end
        check8(stl ? "rd_stall" : (a == 16'h4016 ? "rd4016" : "rd4017"), data, e);
        @(posedge clk);
        #1;
        cyc++;
        rd    = 1'b0;
        stall = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] v, input logic stl,
                             input logic with_rd);
        addr   = a;
        wr     = 1'b1;
        rd     = with_rd;
        stall  = stl;
        tb_en  = 1'b1;
        tb_val = v;
        @(negedge clk);
        check_pads();
        if (!stl && a == 16'h4016) begin
            if (exp_strobe) begin
                snap0 = exp_b0;
                snap1 = exp_b1;
                n0    = 0;
                n1    = 0;
            end
            exp_strobe = v[0];
        end
        @(posedge clk);
        #1;
        cyc++;
        wr    = 1'b0;
        rd    = 1'b0;
        stall = 1'b0;
        tb_en = 1'b0;
    endtask

    task automatic model_reset();
        cyc        = 0;
        exp_b0     = 8'h00;
        exp_b1     = 8'h00;
        pend       = 1'b0;
        exp_strobe = 1'b0;
        snap0      = 8'hFF;
        snap1      = 8'hFF;
        n0         = 0;
        n1         = 0;
        prev_clk   = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; addr = 16'h0; rd = 1'b0; wr = 1'b0; stall = 1'b0;
        tb_en = 1'b0; tb_val = 8'h00;
        pat0 = 8'h89; pat1 = 8'h00; lat0 = 8'h00; lat1 = 8'h00;
        model_reset();

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check8("rst_latch", {7'b0, pad_latch}, 8'h00);
        check8("rst_clk", {7'b0, pad_clk}, 8'h00);
        check8("rst_b0", buttons0, 8'h00);
        check8("rst_b1", buttons1, 8'h00);
        check8("rst_data", data, 8'hFF);
        rst = 1'b0;

        // first poll: latch width, clock pulses, commit
        lat_cnt  = 0;
        clk_rise = 0;
        run_to(P);
        check8("latch_cycles", 8'(lat_cnt), 8'd4);
        check8("clk_pulses", 8'(clk_rise), 8'd7);
        check8("commit_b0", buttons0, 8'h89);
        check8("commit_b1", buttons1, 8'h00);

        // strobe then serial reads, with ignored accesses mixed in
        cpu_write(16'h4016, 8'h01, 1'b0, 1'b0);
        cpu_write(16'h4016, 8'h00, 1'b0, 1'b0);
        repeat (3) cpu_read(16'h4016, 1'b0);
        cpu_read(16'h4016, 1'b1);
        cpu_write(16'h4016, 8'h01, 1'b1, 1'b0);
        cpu_write(16'h4017, 8'h01, 1'b0, 1'b0);
        cpu_write(16'h4016, 8'h00, 1'b0, 1'b1);
        repeat (7) cpu_read(16'h4016, 1'b0);
        repeat (9) cpu_read(16'h4017, 1'b0);
        cpu_write(16'h4016, 8'h01, 1'b0, 1'b1);
        step();
        repeat (2) cpu_read(16'h4016, 1'b0);
        cpu_write(16'h4016, 8'h00, 1'b0, 1'b0);
        repeat (4) cpu_read(16'h4016, 1'b0);

        // second poll with random pads, read both ports out
        pat0 = 8'($urandom);
        pat1 = 8'($urandom);
        run_to(2 * P);
        cpu_write(16'h4016, 8'h01, 1'b0, 1'b0);
        cpu_write(16'h4016, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            cpu_read(16'h4016, 1'b0);
            cpu_read(16'h4017, 1'b0);
        end

        // third poll commits while strobe is held
        pat0 = 8'h01;
        pat1 = 8'($urandom);
        run_to(3 * P - 19);
        cpu_write(16'h4016, 8'h01, 1'b0, 1'b0);
        run_to(3 * P - 14);
        cpu_read(16'h4016, 1'b0);
        run_to(3 * P - 9);
        cpu_read(16'h4017, 1'b0);
        run_to(3 * P + 3);
        repeat (3) cpu_read(16'h4016, 1'b0);
        cpu_write(16'h4016, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            cpu_read(16'h4016, 1'b0);
            cpu_read(16'h4017, 1'b0);
        end

        // reset during the LOW phase of bit 3 of the fourth poll
        pat0 = 8'($urandom);
        pat1 = 8'($urandom);
        run_to(3 * P + PP + 2 * H + 6 * H);
        #2;
        rst = 1'b1;
        #1;
        check8("mid_rst_clk", {7'b0, pad_clk}, 8'h00);
        check8("mid_rst_latch", {7'b0, pad_latch}, 8'h00);
        check8("mid_rst_b0", buttons0, 8'h00);
        check8("mid_rst_b1", buttons1, 8'h00);
        pat0 = 8'($urandom);
        pat1 = 8'($urandom);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cpu_read(16'h4016, 1'b0);
        lat_cnt  = 0;
        clk_rise = 0;
        run_to(P);
        check8("post_rst_latch", 8'(lat_cnt), 8'd4);
        check8("post_rst_b0", buttons0, pat0);
        check8("post_rst_b1", buttons1, pat1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
